board_io_avmm_slave: RTL and testbench

// Avalon-MM responder on the HPS lightweight H2F bridge: the fabric-side end of HPS register accesses to board I/O.

---
 rtl/board_io_avmm_slave.sv | 75 +++++++
 tb/tb_board_io_avmm_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/board_io_avmm_slave.sv
// board_io_avmm_slave: Avalon-MM register block for LEDs, debounced switches/keys and key-press interrupt
module board_io_avmm_slave #(
  parameter int LED_W = 6,
  parameter int SW_W = 4,
  parameter int KEY_W = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] BLOCK_ID = 32'h10DE_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [KEY_W-1:0] key_n_in,
  output logic [LED_W-1:0] led_out
);
  localparam int N = SW_W + KEY_W;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [N-1:0] sync1, sync2, stb, acc;
  logic [CW-1:0] cnt [N];
  logic [KEY_W-1:0] edge_q, mask, key_rise, clr;
  logic [31:0] rd_mux;
  logic wr, unused_ok;
  assign unused_ok = ^avs_writedata;
  assign wr = avs_write & ~avs_read;
  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) acc[i] = (sync2[i] != stb[i]) && (cnt[i] == CMAX);
  end
  // acc marks a bit whose new level has just survived the full debounce window
  assign key_rise = acc[N-1:SW_W] & sync2[N-1:SW_W];
  assign clr = {KEY_W{wr && avs_address == 3'd3}} & avs_writedata[KEY_W-1:0];
  assign rd_mux = avs_address == 3'd0 ? 32'(led_out) :
                  avs_address == 3'd1 ? 32'(stb[SW_W-1:0]) :
                  avs_address == 3'd2 ? 32'(stb[N-1:SW_W]) :
                  avs_address == 3'd3 ? 32'(edge_q) :
                  avs_address == 3'd4 ? 32'(mask) :
                  avs_address == 3'd5 ? BLOCK_ID : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stb <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {~key_n_in, sw_in};
      sync2 <= sync1;
      stb <= stb ^ acc;
      for (int i = 0; i < N; i++) cnt[i] <= (sync2[i] == stb[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
      mask <= '0;
      edge_q <= '0;
      irq <= 1'b0;
      avs_readdata <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
      if (wr && avs_address == 3'd0) led_out <= avs_writedata[LED_W-1:0];
      if (wr && avs_address == 3'd4) mask <= avs_writedata[KEY_W-1:0];
      edge_q <= (edge_q & ~clr) | key_rise;
      irq <= |(edge_q & mask);
    end
  end
endmodule

// File: tb/tb_board_io_avmm_slave.sv
// tb_board_io_avmm_slave: directed stimulus with a window-based debounce/register model checked every cycle
module tb_board_io_avmm_slave;
  localparam int DC = 16;
  localparam logic [31:0] ID = 32'h10DE_0001;
  logic clk = 0, reset = 1, avs_read = 0, avs_write = 0;
  logic [2:0] avs_address = 0;
  logic [31:0] avs_writedata = 0, avs_readdata;
  logic [3:0] sw_in = 0;
  logic [1:0] key_n_in = 2'b11;
  logic avs_readdatavalid, irq;
  logic [5:0] led_out;
  int checks = 0, errors = 0;
  bit started = 0;

  always #10 clk = ~clk;

  board_io_avmm_slave #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .irq(irq), .sw_in(sw_in),
    .key_n_in(key_n_in), .led_out(led_out)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Model: an input bit's accepted level flips once the last DC synchronised samples all disagree with it
  logic [5:0] m_led = 0, m_stb = 0, p1 = 0, p2 = 0;
  logic [1:0] m_mask = 0, m_edge = 0;
  logic m_irq = 0, m_rdv = 0;
  logic [31:0] m_rd = 0;
  logic [5:0] hist [DC] = '{default: '0};

  always @(posedge clk) begin : model
    logic [5:0] s, flip;
    logic [1:0] rise, clr;
    logic [31:0] rv;
    bit w;
    if (reset) begin
      m_led = 0; m_stb = 0; p1 = 0; p2 = 0; m_mask = 0; m_edge = 0;
      m_irq = 0; m_rdv = 0; m_rd = 0;
      for (int j = 0; j < DC; j++) hist[j] = 0;
    end else begin
      s = p2; p2 = p1; p1 = {~key_n_in, sw_in};
      for (int j = 0; j < DC - 1; j++) hist[j] = hist[j+1];
      hist[DC-1] = s;
      flip = 6'h3F;
      for (int j = 0; j < DC; j++) flip &= hist[j] ^ m_stb;
      rise = flip[5:4] & ~m_stb[5:4];
      w = avs_write && !avs_read;
      clr = (w && avs_address == 3) ? avs_writedata[1:0] : 2'b0;
      case (avs_address)
        0: rv = {26'b0, m_led};
        1: rv = {28'b0, m_stb[3:0]};
        2: rv = {30'b0, m_stb[5:4]};
        3: rv = {30'b0, m_edge};
        4: rv = {30'b0, m_mask};
        5: rv = ID;
        default: rv = 0;
      endcase
      if (avs_read) m_rd = rv;
      m_rdv = avs_read;
      m_irq = |(m_edge & m_mask);
      m_edge = (m_edge & ~clr) | rise;
      if (w && avs_address == 0) m_led = avs_writedata[5:0];
      if (w && avs_address == 4) m_mask = avs_writedata[1:0];
      m_stb ^= flip;
    end
  end

  always @(negedge clk) if (started) begin
    chk("model led", led_out, m_led);
    chk("model irq", irq, m_irq);
    chk("model rdv", avs_readdatavalid, m_rdv);
    chk("model rdata", avs_readdata, m_rd);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    tick(1);
    avs_write = 0;
  endtask

  task automatic rd(logic [2:0] a, logic [31:0] e, string nm);
    avs_address = a; avs_read = 1;
    tick(1);
    avs_read = 0;
    chk({nm, " valid"}, avs_readdatavalid, 1);
    chk(nm, avs_readdata, e);
  endtask

  initial begin
    tick(2);
    started = 1;
    reset = 0;
    chk("reset led", led_out, 0);
    chk("reset irq", irq, 0);
    chk("reset rdv", avs_readdatavalid, 0);
    chk("reset rdata", avs_readdata, 0);
    rd(5, ID, "id");
    for (int a = 0; a < 5; a++) rd(3'(a), 0, "reset reg");
    rd(6, 0, "unused 6");
    // LED write and RO write
    wr(0, 32'h2A);
    chk("led after write", led_out, 6'h2A);
    rd(0, 32'h2A, "led readback");
    wr(1, 32'hF);
    rd(1, 0, "sw ro");
    // key0 glitches shorter than the window
    for (int g = 0; g < 3; g++) begin
      key_n_in = 2'b10; tick(5);
      key_n_in = 2'b11; tick(5);
    end
    rd(2, 0, "key glitch");
    rd(3, 0, "edge glitch");
    key_n_in = 2'b10;
    tick(20);
    rd(2, 1, "key pressed");
    rd(3, 1, "edge pressed");
    chk("irq masked", irq, 0);
    // enable interrupt, release, clear, then collide a new press with a clear
    wr(4, 1);
    tick(1);
    chk("irq on mask", irq, 1);
    key_n_in = 2'b11;
    tick(20);
    rd(2, 0, "key released");
    rd(3, 1, "edge after release");
    wr(3, 1);
    tick(1);
    chk("irq after clear", irq, 0);
    rd(3, 0, "edge cleared");
    key_n_in = 2'b10;
    tick(17);
    wr(3, 1);
    tick(1);
    chk("irq set wins", irq, 1);
    rd(3, 1, "edge set wins");
    wr(3, 1);
    chk("irq lag", irq, 1);
    tick(1);
    chk("irq cleared", irq, 0);
    key_n_in = 2'b11;
    tick(20);
    // reset part-way through a switch debounce
    sw_in = 4'b1010;
    tick(10);
    reset = 1;
    tick(1);
    reset = 0;
    chk("led after reset", led_out, 0);
    rd(1, 0, "sw after reset");
    tick(14);
    rd(1, 0, "sw partial");
    tick(3);
    rd(1, 4'hA, "sw settled");
    // back-to-back reads with a write dropped on the first
    wr(0, 32'h15);
    avs_address = 0; avs_read = 1; avs_write = 1; avs_writedata = 32'h3F;
    tick(1);
    avs_write = 0;
    chk("b2b0 valid", avs_readdatavalid, 1);
    chk("b2b0 data", avs_readdata, 32'h15);
    avs_address = 1;
    tick(1);
    chk("b2b1 valid", avs_readdatavalid, 1);
    chk("b2b1 data", avs_readdata, 32'hA);
    avs_address = 2;
    tick(1);
    chk("b2b2 valid", avs_readdatavalid, 1);
    chk("b2b2 data", avs_readdata, 0);
    avs_address = 5;
    tick(1);
    avs_read = 0;
    chk("b2b5 valid", avs_readdatavalid, 1);
    chk("b2b5 data", avs_readdata, ID);
    tick(1);
    chk("b2b end valid", avs_readdatavalid, 0);
    chk("b2b hold data", avs_readdata, ID);
    chk("b2b led", led_out, 6'h15);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
